// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcodes,
// datapath select encodings and the bundled control-word type.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEM_ADDR = 4'd2,
      ST_MEM_RD   = 4'd3,
      ST_LW_WB    = 4'd4,
      ST_MEM_WR   = 4'd5,
      ST_EXEC_R   = 4'd6,
      ST_R_WB     = 4'd7,
      ST_BRANCH   = 4'd8,
      ST_JUMP     = 4'd9,
      ST_ADDI_EX  = 4'd10,
      ST_ADDI_WB  = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_t;

   typedef enum logic [1:0] {
      SRCB_REG    = 2'b00,
      SRCB_FOUR   = 2'b01,
      SRCB_IMM    = 2'b10,
      SRCB_IMM_SH = 2'b11
   } alu_src_b_t;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pc_source_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic       reg_dst;
      alu_src_b_t alu_src_b;
      alu_op_t    alu_op;
      pc_source_t pc_source;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// State-to-control-word decode for the multicycle control unit. Purely
// combinational; enable low forces the whole control word to zero.
module ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_t      cur_state,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   input  logic        enable,
   output ctrl_t       ctrl
);

   always_comb begin
      // NOTE: the whole word is defaulted first so every branch below only
      // lists what it raises; no path leaves a field unassigned (no latch).
      ctrl = '0;
      unique case (cur_state)
         ST_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_source = PCSRC_ALU;
            // IR and PC only advance once the instruction word has arrived
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         ST_DECODE: begin
            ctrl.alu_src_b  = SRCB_IMM_SH;
            ctrl.alu_op     = ALU_ADD;
            ctrl.illegal_op = !is_legal_op(opcode);
         end
         ST_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         ST_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         ST_LW_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ST_MEM_WR: begin
            ctrl.mem_write  = 1'b1;
            ctrl.i_or_d     = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         ST_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALU_FUNCT;
         end
         ST_R_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ST_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
            ctrl.instr_done    = 1'b1;
         end
         ST_JUMP: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PCSRC_JUMP;
            ctrl.instr_done = 1'b1;
         end
         ST_ADDI_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         ST_ADDI_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         default: ctrl = '0;
      endcase
      // reset must silence the datapath immediately, not at the next edge
      if (!enable) ctrl = '0;
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: holds the state register and next-state logic,
// and drives the datapath strobes through ctrl_decode.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic       reg_dst,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_t cur_state;
   state_t next_state;
   logic   ready;
   ctrl_t  ctrl;

   assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (!rst_n) cur_state <= ST_FETCH;
      else        cur_state <= next_state;
   end

   always_comb begin
      next_state = cur_state;
      unique case (cur_state)
         ST_FETCH:    if (ready) next_state = ST_DECODE;
         ST_DECODE: begin
            unique case (opcode)
               OP_RTYPE:     next_state = ST_EXEC_R;
               OP_LW, OP_SW: next_state = ST_MEM_ADDR;
               OP_BEQ:       next_state = ST_BRANCH;
               OP_J:         next_state = ST_JUMP;
               OP_ADDI:      next_state = ST_ADDI_EX;
               default:      next_state = ST_FETCH;
            endcase
         end
         ST_MEM_ADDR: next_state = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD:   if (ready) next_state = ST_LW_WB;
         ST_MEM_WR:   if (ready) next_state = ST_FETCH;
         ST_EXEC_R:   next_state = ST_R_WB;
         ST_ADDI_EX:  next_state = ST_ADDI_WB;
         ST_LW_WB, ST_R_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP:
                      next_state = ST_FETCH;
         default:     next_state = ST_FETCH;
      endcase
   end

   ctrl_decode u_decode (
      .cur_state (cur_state),
      .opcode    (opcode),
      .mem_ready (ready),
      .enable    (rst_n),
      .ctrl      (ctrl)
   );

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign reg_dst       = ctrl.reg_dst;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign instr_done    = ctrl.instr_done;
   assign illegal_op    = ctrl.illegal_op;
   assign state         = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-path model predicts the
// state walk and control word every cycle; latencies are pinned by literals.
module tb_multicycle_control;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic       reg_dst;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       illegal_op;
   } obs_t;

   localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
   localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, AI = 6'b001000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;

   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_write, alu_src_a, reg_dst, instr_done, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;

   logic       n_pc_write, n_pc_write_cond, n_i_or_d, n_mem_read, n_mem_write, n_ir_write;
   logic       n_mem_to_reg, n_reg_write, n_alu_src_a, n_reg_dst, n_instr_done, n_illegal_op;
   logic [1:0] n_alu_src_b, n_alu_op, n_pc_source;
   logic [3:0] n_state;

   int n_checks = 0;
   int n_errors = 0;

   logic        exp_valid = 1'b0;
   logic        chk_alt   = 1'b0;
   logic [3:0]  exp_state;
   logic [17:0] exp_vec, exp_alt;
   logic        last_done, last_done_nw;

   always #5 clk = ~clk;

   multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .reg_dst(reg_dst), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
      .state(state)
   );

   multicycle_control #(.MEM_WAIT_EN(1'b0)) dut_nw (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(1'b0),
      .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .i_or_d(n_i_or_d),
      .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
      .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
      .reg_dst(n_reg_dst), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
      .pc_source(n_pc_source), .instr_done(n_instr_done), .illegal_op(n_illegal_op),
      .state(n_state)
   );

   wire [17:0] dut_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                          ir_write, mem_to_reg, reg_write, alu_src_a, reg_dst,
                          alu_src_b, alu_op, pc_source, instr_done, illegal_op};
   wire [17:0] nw_vec  = {n_pc_write, n_pc_write_cond, n_i_or_d, n_mem_read, n_mem_write,
                          n_ir_write, n_mem_to_reg, n_reg_write, n_alu_src_a, n_reg_dst,
                          n_alu_src_b, n_alu_op, n_pc_source, n_instr_done, n_illegal_op};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Control word each state must present, written straight from the state table.
   function automatic logic [17:0] model(input logic [3:0] st, input logic [5:0] op,
                                         input logic rdy);
      obs_t o;
      o = '0;
      case (st)
         4'd0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
         4'd1:  begin
                   o.alu_src_b  = 2'b11;
                   o.illegal_op = !(op inside {RT, LW, SW, BQ, JP, AI});
                end
         4'd2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         4'd3:  begin o.mem_read = 1; o.i_or_d = 1; end
         4'd4:  begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
         4'd5:  begin o.mem_write = 1; o.i_or_d = 1; o.instr_done = rdy; end
         4'd6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
         4'd7:  begin o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; end
         4'd8:  begin
                   o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1;
                   o.pc_source = 2'b01; o.instr_done = 1;
                end
         4'd9:  begin o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; end
         4'd10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         4'd11: begin o.reg_write = 1; o.instr_done = 1; end
         default: o = '0;
      endcase
      return o;
   endfunction

   always @(negedge clk) begin
      if (exp_valid) begin
         check("state", {28'd0, state}, {28'd0, exp_state});
         check("ctrl_word", {14'd0, dut_vec}, {14'd0, exp_vec});
         check("rw_mw_excl", {31'd0, reg_write & mem_write}, 32'd0);
         if (chk_alt) begin
            check("nw_state", {28'd0, n_state}, {28'd0, exp_state});
            check("nw_ctrl_word", {14'd0, nw_vec}, {14'd0, exp_alt});
         end
      end
   end

   // One clock cycle: opcode is only meaningful in DECODE/MEM_ADDR, so it is
   // scrambled everywhere else to show it is not looked at.
   task automatic step(input logic [3:0] st, input logic [5:0] op, input logic rdy);
      opcode    = (st == 4'd1 || st == 4'd2) ? op : ~op;
      mem_ready = rdy;
      exp_state = st;
      exp_vec   = model(st, op, rdy);
      exp_alt   = model(st, op, 1'b1);
      exp_valid = 1'b1;
      @(negedge clk);
      last_done    = instr_done;
      last_done_nw = n_instr_done;
      @(posedge clk);
      #1;
      exp_valid = 1'b0;
   endtask

   // Builds the expected state walk of one instruction and runs it; the cycle
   // on which the DUT pulses instr_done must equal the literal latency.
   task automatic run_instr(input string name, input logic [5:0] op, input int fstall,
                            input int mstall, input int exp_lat);
      logic [3:0] sq[$];
      logic       rq[$];
      int         done_at, done_nw;
      for (int i = 0; i < fstall; i++) begin sq.push_back(4'd0); rq.push_back(1'b0); end
      sq.push_back(4'd0); rq.push_back(1'b1);
      sq.push_back(4'd1); rq.push_back(1'b0);
      case (op)
         RT: begin sq.push_back(4'd6); rq.push_back(1'b0); sq.push_back(4'd7); rq.push_back(1'b0); end
         LW, SW: begin
            sq.push_back(4'd2); rq.push_back(1'b0);
            for (int i = 0; i < mstall; i++) begin
               sq.push_back((op == LW) ? 4'd3 : 4'd5); rq.push_back(1'b0);
            end
            sq.push_back((op == LW) ? 4'd3 : 4'd5); rq.push_back(1'b1);
            if (op == LW) begin sq.push_back(4'd4); rq.push_back(1'b0); end
         end
         BQ: begin sq.push_back(4'd8); rq.push_back(1'b0); end
         JP: begin sq.push_back(4'd9); rq.push_back(1'b0); end
         AI: begin sq.push_back(4'd10); rq.push_back(1'b0); sq.push_back(4'd11); rq.push_back(1'b0); end
         default: ;
      endcase
      done_at = 0;
      done_nw = 0;
      for (int i = 0; i < sq.size(); i++) begin
         step(sq[i], op, rq[i]);
         if (last_done && done_at == 0) done_at = i + 1;
         if (last_done_nw && done_nw == 0) done_nw = i + 1;
      end
      check({name, "_latency"}, done_at, exp_lat);
      if (chk_alt) check({name, "_nw_latency"}, done_nw, exp_lat);
   endtask

   initial begin
      rst_n     = 1'b0;
      opcode    = RT;
      mem_ready = 1'b1;
      #3;
      check("reset_state", {28'd0, state}, 32'd0);
      check("reset_outputs", {14'd0, dut_vec}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold_state", {28'd0, state}, 32'd0);
      rst_n = 1'b1;

      run_instr("rtype", RT, 0, 0, 4);
      run_instr("lw", LW, 0, 0, 5);
      run_instr("lw_stall", LW, 0, 3, 8);
      run_instr("sw", SW, 0, 0, 4);
      run_instr("sw_stall", SW, 0, 2, 6);
      run_instr("addi", AI, 0, 0, 4);
      run_instr("beq", BQ, 0, 0, 3);
      run_instr("beq_fstall", BQ, 2, 0, 5);
      run_instr("j", JP, 0, 0, 3);
      run_instr("illegal_3f", 6'b111111, 0, 0, 0);
      run_instr("illegal_01", 6'b000001, 1, 0, 0);
      run_instr("addi_after_ill", AI, 0, 0, 4);

      // Reset dropped in the middle of EXEC_R.
      step(4'd0, RT, 1'b1);
      step(4'd1, RT, 1'b0);
      opcode    = ~RT;
      mem_ready = 1'b0;
      #2;
      check("pre_reset_state", {28'd0, state}, 32'd6);
      rst_n = 1'b0;
      #1;
      check("async_reset_state", {28'd0, state}, 32'd0);
      check("async_reset_outputs", {14'd0, dut_vec}, 32'd0);
      @(negedge clk);
      check("reset_no_done", {31'd0, instr_done}, 32'd0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      chk_alt = 1'b1;
      run_instr("rtype_post_reset", RT, 0, 0, 4);
      run_instr("lw_nowait", LW, 0, 0, 5);
      run_instr("j_nowait", JP, 0, 0, 3);
      chk_alt = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port opcode, input, 6, instruction[31:26] from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1, memory access complete this cycle.
REQ-006 SHALL have port pc_write, output, 1, unconditional PC load.
REQ-007 SHALL have port pc_write_cond, output, 1, PC load qualified by the ALU zero flag in the datapath.
REQ-008 SHALL have ports i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src_a: each output, 1, standard multicycle datapath strobes/selects.
REQ-009 SHALL have port reg_dst, output, 1, control of the 5-bit destination mux: 0 = rt (input A), 1 = rd (input B).
REQ-010 SHALL have ports alu_src_b, alu_op, pc_source: each output, 2.
REQ-011 SHALL have ports instr_done, illegal_op: each output, 1, one-cycle pulses.
REQ-012 SHALL have port state, output, 4, current state code for debug.

Function
REQ-013 SHALL be a Moore FSM with codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, LW_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11; codes 12-15 are unused and SHALL go to FETCH.
REQ-014 FETCH SHALL assert mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-015 FETCH SHALL assert ir_write and pc_write only in a cycle with mem_ready=1, then go to DECODE; otherwise it SHALL stay in FETCH.
REQ-016 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00.
REQ-017 DECODE SHALL branch on opcode: 000000->EXEC_R, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 001000->ADDI_EX; any other opcode SHALL pulse illegal_op and go to FETCH.
REQ-018 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_RD for lw or MEM_WR for sw.
REQ-019 MEM_RD (mem_read, i_or_d=1) and MEM_WR (mem_write, i_or_d=1) SHALL hold until mem_ready=1.
REQ-020 On mem_ready=1, MEM_RD SHALL go to LW_WB, and MEM_WR SHALL pulse instr_done and go to FETCH.
REQ-021 LW_WB SHALL assert reg_write, mem_to_reg=1, reg_dst=0.
REQ-022 R_WB SHALL assert reg_write, mem_to_reg=0, reg_dst=1.
REQ-023 ADDI_WB SHALL assert reg_write, mem_to_reg=0, reg_dst=0.
REQ-024 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10.
REQ-025 ADDI_EX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00.
REQ-026 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
REQ-027 JUMP SHALL drive pc_write=1, pc_source=10.
REQ-028 LW_WB, R_WB, ADDI_WB, BRANCH and JUMP SHALL each pulse instr_done and return to FETCH.
REQ-029 Every output not listed for a state SHALL be 0 in that state.
REQ-030 Latency with mem_ready held 1: lw=5, sw=4, R=4, addi=4, beq=3, j=3 cycles.
REQ-031 reg_write and mem_write SHALL never be asserted in the same cycle.
REQ-032 opcode SHALL be sampled only in DECODE and MEM_ADDR.

Reset
REQ-033 rst_n low SHALL immediately force state=FETCH and all outputs to 0, regardless of clk.
REQ-034 A reset asserted mid-instruction SHALL abandon that instruction with no instr_done pulse.
REQ-035 On the first rising edge after rst_n deasserts, the FSM SHALL be in FETCH with FETCH outputs active.

Structure
REQ-036 State codes, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI) and alu_op encodings SHALL live in shared package mips_ctrl_pkg.
REQ-037 The state->output decode SHALL be a single combinational sub-module, ctrl_decode; the state register and next-state logic SHALL stay in multicycle_control.

Verification
REQ-038 Reset test: rst_n=0 mid-EXEC_R -> state=0, all outputs 0 at once; after release, FETCH then DECODE.
REQ-039 R-type test: opcode=000000, mem_ready=1 -> states 0,1,6,7; reg_dst=1 and reg_write=1 only in state 7; instr_done pulses in state 7.
REQ-040 lw with stall test: opcode=100011, mem_ready=0 for 3 cycles in MEM_RD -> MEM_RD held 4 cycles; then LW_WB with reg_dst=0, mem_to_reg=1.
REQ-041 addi/sw test: addi -> ADDI_WB with reg_dst=0; sw -> no reg_write at any point, mem_write=1 in MEM_WR.
REQ-042 Illegal opcode test: opcode=111111 -> illegal_op pulses 1 cycle in DECODE; next state=FETCH; no reg_write or mem_write.
REQ-043 MEM_WAIT_EN=0 test: mem_ready tied 0 -> lw still completes in 5 cycles.
